// File: rtl/pcileech_led_pkg.sv
// Shared types for the status-LED controller.
// Mode encoding for each LED channel.
package pcileech_led_pkg;

    localparam int LED_MODE_W = 3;

    typedef enum logic [LED_MODE_W-1:0] {
        LED_OFF   = 3'd0,
        LED_ON    = 3'd1,
        LED_LEVEL = 3'd2,
        LED_ACT   = 3'd3,
        LED_SLOW  = 3'd4,
        LED_FAST  = 3'd5,
        LED_GATED = 3'd6,
        LED_RSVD  = 3'd7
    } led_mode_t;

endpackage

// File: rtl/pcileech_led_timebase.sv
// Millisecond prescaler and blink phase generator.
// Shared by all LED channels.
module pcileech_led_timebase #(
    parameter int TICK_CYCLES   = 100000,
    parameter int BLINK_HALF_MS = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_ms_o,
    output logic slow_ph_o,
    output logic fast_ph_o
);

    localparam int QTR = BLINK_HALF_MS / 4;
    localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int MW  = $clog2(BLINK_HALF_MS);
    localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [MW-1:0] ms_q, ms_d;
    logic [QW-1:0] qtr_q, qtr_d;
    logic          tick_q, tick_d;
    logic          slow_q, slow_d;
    logic          fast_q, fast_d;

    always_comb begin
        pre_d  = pre_q + PW'(1);
        tick_d = 1'b0;
        ms_d   = ms_q;
        qtr_d  = qtr_q;
        slow_d = slow_q;
        fast_d = fast_q;
        if (pre_q == PW'(TICK_CYCLES - 1)) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
        // Quarter counter stays aligned with ms counter, so its wrap
        // marks every multiple of BLINK_HALF_MS/4.
        if (tick_q) begin
            ms_d  = ms_q + MW'(1);
            qtr_d = qtr_q + QW'(1);
            if (qtr_q == QW'(QTR - 1)) begin
                qtr_d  = '0;
                fast_d = ~fast_q;
            end
            if (ms_q == MW'(BLINK_HALF_MS - 1)) begin
                ms_d   = '0;
                slow_d = ~slow_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            ms_q   <= '0;
            qtr_q  <= '0;
            slow_q <= 1'b0;
            fast_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            ms_q   <= ms_d;
            qtr_q  <= qtr_d;
            slow_q <= slow_d;
            fast_q <= fast_d;
        end
    end

    assign tick_ms_o = tick_q;
    assign slow_ph_o = slow_q;
    assign fast_ph_o = fast_q;

endmodule

// File: rtl/pcileech_led_ctl.sv
// Multi-channel status-LED controller: per-channel mode,
// activity stretch, blink and output polarity.
module pcileech_led_ctl
    import pcileech_led_pkg::*;
#(
    parameter int                 NUM_LED       = 6,
    parameter int                 TICK_CYCLES   = 100000,
    parameter int                 STRETCH_MS    = 50,
    parameter int                 BLINK_HALF_MS = 500,
    parameter logic [NUM_LED-1:0] INVERT_MASK   = {NUM_LED{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          led_enable,
    input  logic [LED_MODE_W*NUM_LED-1:0] led_mode,
    input  logic [NUM_LED-1:0]            led_level,
    input  logic [NUM_LED-1:0]            led_act,
    output logic [NUM_LED-1:0]            led_out,
    output logic                          tick_ms
);

    localparam int SW = $clog2(STRETCH_MS + 1);

    logic               tick;
    logic               slow_ph;
    logic               fast_ph;
    logic [NUM_LED-1:0] on;
    logic [NUM_LED-1:0] out_q, out_d;

    pcileech_led_timebase #(
        .TICK_CYCLES  (TICK_CYCLES),
        .BLINK_HALF_MS(BLINK_HALF_MS)
    ) u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_ms_o(tick),
        .slow_ph_o(slow_ph),
        .fast_ph_o(fast_ph)
    );

    for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
        logic [SW-1:0] str_q, str_d;
        logic          on_c;
        led_mode_t     mode;

        assign mode = led_mode_t'(led_mode[LED_MODE_W*i +: LED_MODE_W]);

        // Stretch runs in every mode so reselecting ACT shows it.
        always_comb begin
            str_d = str_q;
            if (led_act[i]) begin
                str_d = SW'(STRETCH_MS);
            end else if (tick && (str_q != '0)) begin
                str_d = str_q - SW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                str_q <= '0;
            end else begin
                str_q <= str_d;
            end
        end

        always_comb begin
            on_c = 1'b0;
            unique case (mode)
                LED_OFF:   on_c = 1'b0;
                LED_ON:    on_c = 1'b1;
                LED_LEVEL: on_c = led_level[i];
                LED_ACT:   on_c = led_act[i] | (str_q != '0);
                LED_SLOW:  on_c = slow_ph;
                LED_FAST:  on_c = fast_ph;
                LED_GATED: on_c = led_level[i] & slow_ph;
                LED_RSVD:  on_c = 1'b0;
            endcase
        end

        assign on[i] = on_c;
    end

    assign out_d = ({NUM_LED{led_enable}} & on) ^ INVERT_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= INVERT_MASK;
        end else begin
            out_q <= out_d;
        end
    end

    assign led_out = out_q;
    assign tick_ms = tick;

endmodule

// File: tb/tb_pcileech_led_ctl.sv
// Self-checking bench for pcileech_led_ctl with a cycle-count
// based reference model and directed scenarios.
module tb_pcileech_led_ctl;

    localparam int NL = 4;
    localparam int TC = 4;
    localparam int SM = 3;
    localparam int BH = 8;
    localparam logic [3:0] INV = 4'b0010;

    logic        clk;
    logic        rst_n;
    logic        led_enable;
    logic [11:0] led_mode;
    logic [3:0]  led_level;
    logic [3:0]  led_act;
    logic [3:0]  led_out;
    logic        tick_ms;

    pcileech_led_ctl #(
        .NUM_LED      (NL),
        .TICK_CYCLES  (TC),
        .STRETCH_MS   (SM),
        .BLINK_HALF_MS(BH),
        .INVERT_MASK  (INV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .led_enable(led_enable),
        .led_mode  (led_mode),
        .led_level (led_level),
        .led_act   (led_act),
        .led_out   (led_out),
        .tick_ms   (tick_ms)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] setm(input int m0, input int m1,
                                          input int m2, input int m3);
        return {m3[2:0], m2[2:0], m1[2:0], m0[2:0]};
    endfunction

    // Reference model: phases derived from edges since release.
    int         k = 0;
    int         rem [4] = '{0, 0, 0, 0};
    logic [3:0] exp_out = INV;
    logic       exp_tick = 1'b0;
    bit         m_tk, m_slow, m_fast, m_on;
    int         m_used, m_md;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < 4; i++) rem[i] = 0;
            exp_out = INV;
            exp_tick = 1'b0;
        end else begin
            m_tk   = (k > 0) && (k % TC == 0);
            m_used = (k > 0) ? (k - 1) / TC : 0;
            m_slow = ((m_used / BH) % 2) == 1;
            m_fast = ((m_used / (BH / 4)) % 2) == 1;
            for (int i = 0; i < 4; i++) begin
                m_md = int'(led_mode[3*i +: 3]);
                case (m_md)
                    1: m_on = 1;
                    2: m_on = led_level[i];
                    3: m_on = led_act[i] || (rem[i] != 0);
                    4: m_on = m_slow;
                    5: m_on = m_fast;
                    6: m_on = led_level[i] && m_slow;
                    default: m_on = 0;
                endcase
                exp_out[i] = (led_enable & m_on) ^ INV[i];
                if (led_act[i]) rem[i] = SM;
                else if (m_tk && rem[i] > 0) rem[i] = rem[i] - 1;
            end
            k = k + 1;
            exp_tick = (k % TC == 0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_out", 32'(led_out), 32'(exp_out));
            chk("model_tick", 32'(tick_ms), 32'(exp_tick));
        end
    end

    task automatic wait_change(input int b, output int t);
        logic prev;
        prev = led_out[b];
        t = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (led_out[b] !== prev) begin
                t = cyc;
                return;
            end
        end
        chk("wait_change_timeout", 32'(b), 32'hffff);
    endtask

    task automatic count_on_ticks(output int ticks);
        int n;
        ticks = 0;
        n = 0;
        while (led_out[0] && n < 60) begin
            if (tick_ms) ticks++;
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("act_off_timeout", 32'(n), 32'(0));
    endtask

    int t0, t1, t2, tk_cnt, n;

    initial begin
        clk = 0;
        rst_n = 1;
        led_enable = 0;
        led_mode = '0;
        led_level = '0;
        led_act = '0;
        #1 rst_n = 0;
        cmp_en = 1;
        led_mode = setm(1, 1, 1, 1);
        led_level = 4'hf;
        led_enable = 1;

        // Reset state and first tick timing.
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(led_out), 32'h2);
        chk("rst_tick", 32'(tick_ms), 32'h0);
        led_mode = '0;
        led_level = '0;
        led_enable = 0;
        rst_n = 1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk("first_tick", 32'(tick_ms), (e == 4) ? 32'h1 : 32'h0);
        end
        repeat (3) @(negedge clk);
        chk("tick_gap", 32'(tick_ms), 32'h0);
        @(negedge clk);
        chk("tick_period", 32'(tick_ms), 32'h1);

        // Static modes and global enable.
        led_mode = setm(1, 1, 2, 0);
        led_level = 4'b0100;
        led_enable = 1;
        @(negedge clk);
        chk("static_on", 32'(led_out), 32'h5);
        led_enable = 0;
        @(negedge clk);
        chk("static_dis", 32'(led_out), 32'h2);

        // Activity stretch.
        led_mode = setm(3, 0, 0, 0);
        led_level = 0;
        led_enable = 1;
        repeat (2) @(negedge clk);
        chk("act_idle", 32'(led_out), 32'h2);
        led_act = 4'b0001;
        @(negedge clk);
        led_act = 0;
        chk("act_on", 32'(led_out), 32'h3);
        count_on_ticks(tk_cnt);
        chk("act_ticks", 32'(tk_cnt), 32'd3);

        // Retrigger after two ticks.
        repeat (3) @(negedge clk);
        led_act = 4'b0001;
        @(negedge clk);
        led_act = 0;
        tk_cnt = 0;
        n = 0;
        while (tk_cnt < 2 && n < 40) begin
            @(negedge clk);
            if (tick_ms) tk_cnt++;
            n++;
        end
        chk("retrig_mid_on", 32'(led_out[0]), 32'h1);
        led_act = 4'b0001;
        @(negedge clk);
        led_act = 0;
        count_on_ticks(tk_cnt);
        chk("retrig_ticks", 32'(tk_cnt), 32'd3);

        // Slow and fast blink periods.
        led_mode = setm(4, 5, 0, 0);
        wait_change(0, t0);
        wait_change(0, t1);
        wait_change(0, t2);
        chk("slow_period", 32'(t2 - t1), 32'd32);
        wait_change(1, t0);
        wait_change(1, t1);
        wait_change(1, t2);
        chk("fast_period", 32'(t2 - t1), 32'd8);

        // Gated blink and reserved mode.
        led_mode = setm(0, 0, 6, 7);
        led_level = 4'b1100;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (i % 5 == 4) led_level[2] = ~led_level[2];
        end
        chk("rsvd_off", 32'(led_out[3]), 32'h0);
        led_level = 4'b1000;
        repeat (2) @(negedge clk);
        chk("gated_low", 32'(led_out[2]), 32'h0);
        chk("rsvd_off2", 32'(led_out[3]), 32'h0);

        // Asynchronous reset mid-operation.
        led_mode = setm(3, 5, 4, 0);
        led_level = 0;
        n = 0;
        while (led_out[2] !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("slow_on_seen", 32'(led_out[2]), 32'h1);
        led_act = 4'b0001;
        @(negedge clk);
        led_act = 0;
        chk("act_before_rst", 32'(led_out[0]), 32'h1);
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk("async_rst_out", 32'(led_out), 32'h2);
        chk("async_rst_tick", 32'(tick_ms), 32'h0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_act", 32'(led_out[0]), 32'h0);
        chk("post_rst_slow", 32'(led_out[2]), 32'h0);
        chk("post_rst_fast", 32'(led_out[1]), 32'h1);
        repeat (20) @(negedge clk);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcileech_led_ctl.md
Name: pcileech_led_ctl

Overview:
- Parametrised status-LED controller for the board top modules.
- Replaces the direct wiring of single state bits onto board LEDs with NUM_LED independently configurable channels.
- Each channel has a selectable mode: off, on, follow-level, activity pulse-stretch, slow blink, fast blink, or gated blink.
- Provides a shared millisecond time base and per-board output polarity, so every board (NeTV2, Screamer, AC701, ...) instantiates one block between its status sources and its LED pins.

Parameters:
- NUM_LED, 6, number of LED channels (1..32).
- TICK_CYCLES, 100000, clk cycles per 1 ms tick (100 MHz clk).
- STRETCH_MS, 50, activity stretch length in ticks (1..65535).
- BLINK_HALF_MS, 500, slow-blink half period in ticks; must be a multiple of 4, >= 4.
- INVERT_MASK, {NUM_LED{1'b0}}, bit i = 1 means channel i is active-low at the pin.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- led_enable  in  1  global enable; 0 forces all channels to the off level.
- led_mode  in  3*NUM_LED  per-channel mode; channel i uses bits [3i+2:3i].
- led_level  in  NUM_LED  per-channel level source.
- led_act  in  NUM_LED  per-channel single-cycle activity strobe.
- led_out  out  NUM_LED  registered pin drive, polarity already applied.
- tick_ms  out  1  registered one-cycle pulse, once per TICK_CYCLES.

Behaviour:
- Reset, asynchronous assert:
  - led_out = INVERT_MASK (all channels off); tick_ms = 0.
  - Prescaler, ms counter, blink phases and all stretch counters = 0.
  - Release is synchronous to clk; first tick_ms occurs TICK_CYCLES cycles after release.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps.
  - tick_ms = 1 for the cycle after the counter equals TICK_CYCLES-1.
- Blink time base:
  - ms counter advances on tick_ms, range 0..BLINK_HALF_MS-1.
  - On wrap, slow_ph toggles.
  - fast_ph toggles each time the ms counter crosses a multiple of BLINK_HALF_MS/4.
  - Both phases start at 0 (off).
- Stretch counter, per channel, width clog2(STRETCH_MS+1):
  - Runs regardless of mode.
  - led_act = 1 loads STRETCH_MS; this retriggers and has priority over decrement in the same cycle.
  - Otherwise decrements on tick_ms while non-zero; saturates at 0.
- Mode decode, on_i:
  - 0 OFF: 0.
  - 1 ON: 1.
  - 2 LEVEL: led_level[i].
  - 3 ACT: led_act[i] OR stretch_i != 0. Light is on the cycle after the strobe and stays on until the stretch counter reaches 0.
  - 4 SLOW: slow_ph.
  - 5 FAST: fast_ph.
  - 6 GATED: led_level[i] AND slow_ph.
  - 7 reserved: 0.
- Output:
  - led_out[i] <= (led_enable & on_i) ^ INVERT_MASK[i].
  - Latency is 1 cycle from any input change to the pin.
- Mode change takes effect on the next cycle. A stretch countdown already in progress is kept and visible if mode 3 is reselected.
- led_enable = 0 does not stop counters or phases; re-enabling resumes with the current phase.
- Reset mid-countdown clears everything immediately; the output returns to the off level without waiting for clk.

Decomposition:
- Shared package pcileech_led_pkg holds:
  - typedef enum logic [2:0] led_mode_t: LED_OFF, LED_ON, LED_LEVEL, LED_ACT, LED_SLOW, LED_FAST, LED_GATED, LED_RSVD.
  - Localparam LED_MODE_W = 3.
- One natural sub-module: pcileech_led_timebase. It holds the prescaler, ms counter, slow_ph and fast_ph, and outputs tick_ms, slow_ph and fast_ph.
- Per-channel stretch counters and mode decode are a generate loop in pcileech_led_ctl.

Test Plan:
Bench parameters: NUM_LED=4, TICK_CYCLES=4, STRETCH_MS=3, BLINK_HALF_MS=8, INVERT_MASK=4'b0010.
1. Reset: hold rst_n=0 with any inputs -> led_out=4'b0010 and tick_ms=0. Release -> first tick_ms pulse exactly 4 cycles later, then every 4 cycles.
2. Static modes: set modes ch0=ON, ch1=ON, ch2=LEVEL (level=1), ch3=OFF, led_enable=1 -> led_out=4'b0101 one cycle later. Drop led_enable -> led_out=4'b0010 next cycle.
3. Activity stretch: ch0=ACT, one-cycle led_act[0] -> led_out[0]=1 next cycle, stays 1 through 3 tick_ms pulses, returns to 0 the cycle after the third tick. A second strobe after 2 ticks extends the on-time to 3 ticks from the second strobe.
4. Blink: ch0=SLOW, ch1=FAST -> pin 0 toggles every 8 ticks (32 cycles). Channel 1's logical state toggles every 2 ticks (8 cycles); its pin is inverted, so led_out[1] reads 1 at the start.
5. Gated blink and reserved mode: ch2=GATED, toggle led_level[2] mid-phase -> the output follows slow_ph only while the level is 1. ch3 mode=7 -> led_out[3]=0 always.
6. Reset mid-operation: assert rst_n=0 asynchronously (between clk edges) during an ACT countdown and a SLOW on-phase -> led_out=4'b0010 immediately. After release, the stretch counter is 0 and blink restarts from the off phase.
